// File: rtl/fifo_mem_prog_if.sv
// Producer/consumer bundle for fifo_mem_prog: request strobes, data paths and status.
// Clock and reset stay outside the bundle as plain module ports.
interface fifo_mem_prog_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic                  trans_write;
  logic                  trans_read;
  logic                  flush;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic [LW-1:0]         level_out;
  logic                  full_ind;
  logic                  empty_ind;
  logic                  afull_ind;
  logic                  aempty_ind;
  logic                  threshold_ind;
  logic                  overflow_ind;
  logic                  underflow_ind;

  modport master (
    output trans_write, trans_read, flush, err_clr, data_in,
    input  data_out, data_valid, level_out, full_ind, empty_ind,
           afull_ind, aempty_ind, threshold_ind, overflow_ind, underflow_ind
  );

  modport slave (
    input  trans_write, trans_read, flush, err_clr, data_in,
    output data_out, data_valid, level_out, full_ind, empty_ind,
           afull_ind, aempty_ind, threshold_ind, overflow_ind, underflow_ind
  );
endinterface

// File: rtl/fifo_mem_prog.sv
// Single-clock FIFO with programmable almost-full/empty and threshold flags, flush,
// sticky overflow/underflow and selectable registered-read or first-word-fall-through output.
module fifo_mem_prog #(
  parameter int DATA_WIDTH      = 16,
  parameter int DEPTH           = 16,
  parameter int THRESHOLD_VALUE = DEPTH / 2,
  parameter int AFULL_MARGIN    = 2,
  parameter int AEMPTY_MARGIN   = 2,
  parameter int FWFT            = 0
) (
  input  logic            clk_in,
  input  logic            areset,
  fifo_mem_prog_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL   = LW'(DEPTH);
  localparam logic [LW-1:0] AFULL_LVL  = LW'(DEPTH - AFULL_MARGIN);
  localparam logic [LW-1:0] AEMPTY_LVL = LW'(AEMPTY_MARGIN);
  localparam logic [LW-1:0] THR_LVL    = LW'(THRESHOLD_VALUE);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_mem_prog: DEPTH must be a power of 2 and at least 2");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d, vld_q, vld_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [DATA_WIDTH-1:0] head;
  logic                  rd_acc, wr_acc;

  assign head = mem[rptr_q];

  always_comb begin
    // flush masks both requests so it can neither move data nor raise an error
    rd_acc  = bus.trans_read && (level_q != '0) && !bus.flush;
    wr_acc  = bus.trans_write && ((level_q != FULL_LVL) || rd_acc) && !bus.flush;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (bus.flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + 1'b1;
      if (rd_acc) rptr_d = rptr_q + 1'b1;
      if (wr_acc && !rd_acc)      level_d = level_q + 1'b1;
      else if (rd_acc && !wr_acc) level_d = level_q - 1'b1;
    end

    ovf_d = bus.err_clr ? 1'b0 : ovf_q;
    if (bus.trans_write && !bus.flush && !wr_acc) ovf_d = 1'b1;
    udf_d = bus.err_clr ? 1'b0 : udf_q;
    if (bus.trans_read && !bus.flush && (level_q == '0)) udf_d = 1'b1;

    // FWFT keeps a shadow of the visible head so the output holds once the FIFO drains
    if (FWFT != 0) begin
      vld_d  = 1'b0;
      dout_d = (level_q != '0) ? head : dout_q;
    end else begin
      vld_d  = rd_acc;
      dout_d = rd_acc ? head : dout_q;
    end
  end

  always_ff @(posedge clk_in or posedge areset) begin
    if (areset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      vld_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      vld_q   <= vld_d;
      dout_q  <= dout_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_acc) mem[wptr_q] <= bus.data_in;
  end

  assign bus.data_out      = ((FWFT != 0) && (level_q != '0)) ? head : dout_q;
  assign bus.data_valid    = (FWFT != 0) ? (level_q != '0) : vld_q;
  assign bus.level_out     = level_q;
  assign bus.full_ind      = (level_q == FULL_LVL);
  assign bus.empty_ind     = (level_q == '0);
  assign bus.afull_ind     = (level_q >= AFULL_LVL);
  assign bus.aempty_ind    = (level_q <= AEMPTY_LVL);
  assign bus.threshold_ind = (level_q >= THR_LVL);
  assign bus.overflow_ind  = ovf_q;
  assign bus.underflow_ind = udf_q;
endmodule

// File: tb/tb_fifo_mem_prog.sv
// Directed bench for fifo_mem_prog: a registered-read instance and an FWFT instance.
module tb_fifo_mem_prog;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total  = 0;
  int   passed = 0;
  int   dv_cnt = 0;

  fifo_mem_prog_if #(.DATA_WIDTH(16), .DEPTH(16)) bus0 ();
  fifo_mem_prog_if #(.DATA_WIDTH(16), .DEPTH(16)) bus1 ();

  fifo_mem_prog #(.FWFT(0)) u_std  (.clk_in(clk), .areset(rst), .bus(bus0));
  fifo_mem_prog #(.FWFT(1)) u_fwft (.clk_in(clk), .areset(rst), .bus(bus1));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_level"},  32'(bus0.level_out), 0);
    chk({tag, "_empty"},  32'(bus0.empty_ind), 1);
    chk({tag, "_full"},   32'(bus0.full_ind), 0);
    chk({tag, "_aempty"}, 32'(bus0.aempty_ind), 1);
    chk({tag, "_afull"},  32'(bus0.afull_ind), 0);
    chk({tag, "_thr"},    32'(bus0.threshold_ind), 0);
    chk({tag, "_dout"},   32'(bus0.data_out), 0);
    chk({tag, "_dv"},     32'(bus0.data_valid), 0);
    chk({tag, "_ovf"},    32'(bus0.overflow_ind), 0);
    chk({tag, "_udf"},    32'(bus0.underflow_ind), 0);
  endtask

  initial begin
    bus0.trans_write = 0; bus0.trans_read = 0; bus0.flush = 0; bus0.err_clr = 0; bus0.data_in = '0;
    bus1.trans_write = 0; bus1.trans_read = 0; bus1.flush = 0; bus1.err_clr = 0; bus1.data_in = '0;
    #2;
    chk_reset("rst");
    chk("rst_fwft_dv", 32'(bus1.data_valid), 0);
    #10 rst = 1'b0;

    // 1: write 1..15 then read them back
    for (int i = 1; i <= 15; i++) begin
      bus0.trans_write = 1; bus0.data_in = 16'(i);
      tick();
      chk("t1_wlvl", 32'(bus0.level_out), 32'(i));
      chk("t1_wthr", 32'(bus0.threshold_ind), (i >= 8) ? 1 : 0);
      chk("t1_waem", 32'(bus0.aempty_ind), (i <= 2) ? 1 : 0);
    end
    bus0.trans_write = 0;
    for (int k = 1; k <= 15; k++) begin
      bus0.trans_read = 1;
      tick();
      if (bus0.data_valid === 1'b1) dv_cnt++;
      chk("t1_dout", 32'(bus0.data_out), 32'(k));
      chk("t1_rthr", 32'(bus0.threshold_ind), ((15 - k) >= 8) ? 1 : 0);
    end
    bus0.trans_read = 0;
    tick();
    chk("t1_dvcnt", 32'(dv_cnt), 15);
    chk("t1_dvlow", 32'(bus0.data_valid), 0);
    chk("t1_hold", 32'(bus0.data_out), 15);
    chk("t1_empty", 32'(bus0.empty_ind), 1);
    chk("t1_ovf", 32'(bus0.overflow_ind), 0);
    chk("t1_udf", 32'(bus0.underflow_ind), 0);

    // 2: fill to full, overflow, clear
    for (int i = 0; i < 16; i++) begin
      bus0.trans_write = 1; bus0.data_in = 16'(16'h0100 + i);
      tick();
      chk("t2_afull", 32'(bus0.afull_ind), ((i + 1) >= 14) ? 1 : 0);
      chk("t2_full", 32'(bus0.full_ind), ((i + 1) == 16) ? 1 : 0);
    end
    chk("t2_level", 32'(bus0.level_out), 16);
    bus0.data_in = 16'hDEAD;
    tick();
    chk("t2_ovf", 32'(bus0.overflow_ind), 1);
    chk("t2_lvl17", 32'(bus0.level_out), 16);
    bus0.trans_write = 0;
    tick();
    chk("t2_sticky", 32'(bus0.overflow_ind), 1);
    bus0.err_clr = 1;
    tick();
    bus0.err_clr = 0;
    chk("t2_clr", 32'(bus0.overflow_ind), 0);

    // 3: read+write at full, then drain
    bus0.trans_read = 1; bus0.trans_write = 1; bus0.data_in = 16'hAAAA;
    tick();
    bus0.trans_write = 0;
    chk("t3_level", 32'(bus0.level_out), 16);
    chk("t3_ovf", 32'(bus0.overflow_ind), 0);
    chk("t3_dout0", 32'(bus0.data_out), 32'h0100);
    chk("t3_dv", 32'(bus0.data_valid), 1);
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("t3_drain", 32'(bus0.data_out), (k == 16) ? 32'hAAAA : 32'(32'h0100 + k));
      chk("t3_dlvl", 32'(bus0.level_out), 32'(16 - k));
    end
    bus0.trans_read = 0;
    tick();
    chk("t3_empty", 32'(bus0.empty_ind), 1);

    // 4: underflow, then FWFT fall-through
    bus0.trans_read = 1;
    tick();
    bus0.trans_read = 0;
    chk("t4_udf", 32'(bus0.underflow_ind), 1);
    chk("t4_dhold", 32'(bus0.data_out), 32'hAAAA);
    chk("t4_dv", 32'(bus0.data_valid), 0);
    bus0.err_clr = 1;
    tick();
    bus0.err_clr = 0;
    chk("t4_uclr", 32'(bus0.underflow_ind), 0);
    chk("t4_fdv0", 32'(bus1.data_valid), 0);
    bus1.trans_write = 1; bus1.data_in = 16'h0042;
    tick();
    bus1.data_in = 16'h0011;
    chk("t4_fdout", 32'(bus1.data_out), 32'h0042);
    chk("t4_fdv", 32'(bus1.data_valid), 1);
    tick();
    bus1.trans_write = 0;
    chk("t4_fhead", 32'(bus1.data_out), 32'h0042);
    bus1.trans_read = 1;
    tick();
    chk("t4_fnext", 32'(bus1.data_out), 32'h0011);
    tick();
    bus1.trans_read = 0;
    chk("t4_fempty", 32'(bus1.data_valid), 0);
    chk("t4_fhold", 32'(bus1.data_out), 32'h0011);

    // 5: pointer wrap at constant level 3
    for (int i = 0; i < 3; i++) begin
      bus0.trans_write = 1; bus0.data_in = 16'(16'h0200 + i);
      tick();
    end
    bus0.trans_read = 1;
    for (int i = 0; i < 40; i++) begin
      bus0.data_in = 16'(16'h0203 + i);
      tick();
      chk("t5_dout", 32'(bus0.data_out), 32'(32'h0200 + i));
      chk("t5_lvl", 32'(bus0.level_out), 3);
    end
    bus0.trans_write = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_tail", 32'(bus0.data_out), 32'(32'h0228 + i));
    end
    bus0.trans_read = 0;

    // 6: flush with read+write, then async reset mid-burst
    bus0.trans_write = 1;
    for (int i = 0; i < 5; i++) begin
      bus0.data_in = 16'(16'h0300 + i);
      tick();
    end
    bus0.trans_write = 0; bus0.trans_read = 1;
    tick();
    chk("t6_pre", 32'(bus0.data_out), 32'h0300);
    bus0.flush = 1; bus0.trans_write = 1;
    tick();
    bus0.flush = 0; bus0.trans_write = 0; bus0.trans_read = 0;
    chk("t6_flvl", 32'(bus0.level_out), 0);
    chk("t6_fempty", 32'(bus0.empty_ind), 1);
    chk("t6_fdv", 32'(bus0.data_valid), 0);
    chk("t6_fdout", 32'(bus0.data_out), 32'h0300);
    chk("t6_fovf", 32'(bus0.overflow_ind), 0);
    chk("t6_fudf", 32'(bus0.underflow_ind), 0);
    bus0.trans_read = 1;
    tick();
    bus0.trans_read = 0;
    chk("t6_udf", 32'(bus0.underflow_ind), 1);
    bus0.trans_write = 1;
    for (int i = 0; i < 10; i++) begin
      bus0.data_in = 16'(16'h0400 + i);
      tick();
    end
    bus0.trans_read = 1;
    tick();
    chk("t6_bdv", 32'(bus0.data_valid), 1);
    chk("t6_bthr", 32'(bus0.threshold_ind), 1);
    #2 rst = 1'b1;
    #1;
    chk_reset("t6_arst");
    bus0.trans_write = 0; bus0.trans_read = 0;
    #3 rst = 1'b0;
    tick();
    chk("t6_post", 32'(bus0.level_out), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
